seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Wishbone-mapped controller for the Nexys 4 DDR eight-digit seven-segment display. It holds the displayed value and a control register, sequences the digit scan, and applies per-digit enable, PWM brightness and blink gating before driving anodes and cathodes. It sits on the SoC Wishbone bus as a single slave and replaces any free-running scan logic for the display.

## Interface
- CLOCKFREQ, 100000000: CLK_I frequency in Hz.
- REFRESH_HZ, 500: full 8-digit frame rate in Hz.
- BLINK_HZ, 2: blink rate in Hz, one on/off period.
- CLK_I  in  1  system clock
- RST_I  in  1  reset; asynchronous, active-high
- ADR_I  in  4  byte address; [3:2] selects register, [1:0] ignored
- DAT_I  in  32  write data
- DAT_O  out  32  read data, valid while ACK_O=1
- STB_I  in  1  strobe
- CYC_I  in  1  bus cycle
- WE_I  in  1  1=write, 0=read
- ACK_O  out  1  single-cycle acknowledge
- O_anode  out  8  one-hot digit select, active-high, bit n = digit n
- O_cathode  out  7  segments a..g, active-low, DP not driven

## Operation
- Registers: 0x0 VALUE (RW, eight hex nibbles, nibble n → digit n); 0x4 CTRL (RW: [7:0] digit enable mask, [15:8] blink mask, [19:16] brightness, [31] display enable, other bits read 0); 0x8 STATUS (RO: [2:0] current digit, [8] blink phase); 0xC reads 0, writes ignored.
- Reset values: VALUE=0x00000000; CTRL=0x800F00FF (enabled, all digits on, no blink, brightness 15); O_anode=0x00; O_cathode=7'h7F; ACK_O=0; DAT_O=0; all counters 0; blink phase 0.
- Prescaler: PHASE_DIV = CLOCKFREQ/(REFRESH_HZ*128), minimum 1. Emits one phase tick every PHASE_DIV cycles.
- Scan counter: 7 bits, increments on each phase tick, wraps 127→0. [6:4] = digit index, [3:0] = PWM phase.
- Blink: counter toggles blink phase every CLOCKFREQ/(2*BLINK_HZ) cycles.
- Digit d is lit when all hold: CTRL[31]=1, mask[d]=1, PWM phase ≤ brightness, and not (blink mask[d]=1 and blink phase=1).
- Lit: O_anode = 1<<d; O_cathode = hex pattern of VALUE nibble d (0→0000001, 1→1001111, …, F→0111000, standard team table).
- Unlit: O_anode=0x00, O_cathode=7'h7F.
- Brightness: 0 gives 1/16 duty, 15 gives 16/16 duty.
- Writes to VALUE or CTRL do not reset the scan or blink counters.

## Timing
- Request accepted when CYC_I&STB_I&~ACK_O. ACK_O rises the next cycle for exactly one cycle, so back-to-back strobes get an ACK every second cycle.
- Write: register updates on the same edge ACK_O rises. Display reflects the new value on the following cycle's outputs.
- Read: DAT_O is registered and valid with ACK_O; 0 when ACK_O=0.
- STB_I dropped before ACK_O: a request already accepted still completes with its ACK and write; no abort.
- O_anode and O_cathode are registered, 1 cycle after the scan/gating state. Anode and cathode always change on the same edge, with no one-cycle mismatch.
- RST_I mid-transfer: ACK_O and all state clear immediately. The pending write is lost.
- Digit change: on a digit change, O_anode goes straight from one one-hot value to the next. No more than one anode bit is ever high.

## Structure
- Shared package seg_pkg holds the register offsets, CTRL field positions, reset constants and the 16-entry cathode pattern table.
- One sub-module, seg_hex_decode: combinational nibble → 7-bit active-low pattern, shared with any other display block.
- Top-level contains the Wishbone slave, prescaler, scan/blink counters and the output gating register.

## Test plan
Test parameters: CLOCKFREQ=1280, REFRESH_HZ=10, BLINK_HZ=5. This gives 1 cycle per phase, 16 cycles per digit, 128 cycles per frame and blink toggling every 128 cycles.
- Reset, write VALUE=0x89ABCDEF → over one frame, digit 0 shows F (0111000) and digit 7 shows 8 (0000000). Each anode is high for 16 consecutive cycles.
- Write CTRL=0x800F0005 → O_anode=0 for digits 1,3,4,5,6,7. Digits 0 and 2 are lit 16 cycles each.
- Write brightness 3 (CTRL=0x800300FF) → each digit is lit 4 of 16 phase cycles. With CTRL[31]=0, O_anode stays 0 and O_cathode stays 7F.
- Write CTRL=0x800F01FF → digit 0 is dark in alternate 128-cycle blink periods; STATUS[8] tracks the phase.
- Wishbone: STB/CYC held high for 6 cycles → 3 ACK pulses. A read of 0x4 after reset returns 0x800F00FF, and a read of 0xC returns 0.
- Assert RST_I mid-write with ACK pending → ACK_O=0, VALUE=0, O_anode=0x00 on the same cycle. Normal scan resumes after release.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: register map, CTRL layout, reset constants and segment patterns for the display controller
package seg_pkg;
    localparam logic [1:0] REG_VALUE  = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    typedef struct packed {
        logic       en;
        logic [10:0] pad;
        logic [3:0] bright;
        logic [7:0] bmask;
        logic [7:0] mask;
    } ctrl_t;

    localparam logic [31:0] CTRL_RST   = 32'h800F00FF;
    localparam logic [31:0] CTRL_WMASK = 32'h800FFFFF;
    localparam logic [6:0]  SEG_OFF    = 7'h7F;

    // bit 6 = segment a ... bit 0 = segment g, active-low
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: Wishbone slave bus bundle for the display controller
interface seg_scan_ctrl_if;
    logic [3:0]  ADR_I;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        STB_I;
    logic        CYC_I;
    logic        WE_I;
    logic        ACK_O;

    modport master (output ADR_I, DAT_I, STB_I, CYC_I, WE_I, input DAT_O, ACK_O);
    modport slave  (input ADR_I, DAT_I, STB_I, CYC_I, WE_I, output DAT_O, ACK_O);
endinterface

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: hex nibble to active-low seven-segment pattern
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: Wishbone-mapped eight-digit seven-segment scan controller with PWM and blink
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CLOCKFREQ  = 100000000,
    parameter int REFRESH_HZ = 500,
    parameter int BLINK_HZ   = 2
) (
    input  logic           CLK_I,
    input  logic           RST_I,
    seg_scan_ctrl_if.slave bus,
    output logic [7:0]     O_anode,
    output logic [6:0]     O_cathode
);
    localparam int PHASE_RAW = CLOCKFREQ / (REFRESH_HZ * 128);
    localparam int PHASE_DIV = PHASE_RAW < 1 ? 1 : PHASE_RAW;
    localparam int BLINK_RAW = CLOCKFREQ / (2 * BLINK_HZ);
    localparam int BLINK_DIV = BLINK_RAW < 1 ? 1 : BLINK_RAW;
    localparam int PW = PHASE_DIV > 1 ? $clog2(PHASE_DIV) : 1;
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0] pre_cnt;
    logic [BW-1:0] blink_cnt;
    logic [6:0]    scan;
    logic          blink;
    logic [31:0]   value;
    ctrl_t         ctrl;
    logic [31:0]   rd_data;
    logic [2:0]    digit;
    logic [3:0]    nib;
    logic [6:0]    seg;
    logic          req, tick, bdone, lit, unused_adr;

    assign unused_adr = ^bus.ADR_I[1:0];
    assign digit = scan[6:4];
    assign nib   = value[{digit, 2'b00} +: 4];

    seg_hex_decode u_dec (.nib(nib), .seg(seg));

    // bus request, counter terminal counts, lit gating and read mux
    always_comb begin
        req     = bus.CYC_I & bus.STB_I & ~bus.ACK_O;
        tick    = pre_cnt == PW'(PHASE_DIV - 1);
        bdone   = blink_cnt == BW'(BLINK_DIV - 1);
        lit     = ctrl.en & ctrl.mask[digit] & (scan[3:0] <= ctrl.bright) & ~(ctrl.bmask[digit] & blink);
        rd_data = bus.ADR_I[3:2] == REG_VALUE  ? value :
                  bus.ADR_I[3:2] == REG_CTRL   ? 32'(ctrl) :
                  bus.ADR_I[3:2] == REG_STATUS ? {23'd0, blink, 5'd0, digit} : 32'd0;
    end

    // free-running prescaler, scan counter and blink phase; untouched by register writes
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            pre_cnt   <= '0;
            scan      <= '0;
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else begin
            pre_cnt   <= tick ? '0 : pre_cnt + 1'b1;
            scan      <= tick ? scan + 1'b1 : scan;
            blink_cnt <= bdone ? '0 : blink_cnt + 1'b1;
            blink     <= bdone ? ~blink : blink;
        end
    end

    // Wishbone slave: one-cycle ack, register write on the ack edge, registered read data
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            bus.ACK_O <= 1'b0;
            bus.DAT_O <= '0;
            value     <= '0;
            ctrl      <= ctrl_t'(CTRL_RST);
        end else begin
            bus.ACK_O <= req;
            bus.DAT_O <= (req & ~bus.WE_I) ? rd_data : '0;
            if (req & bus.WE_I & (bus.ADR_I[3:2] == REG_VALUE)) value <= bus.DAT_I;
            if (req & bus.WE_I & (bus.ADR_I[3:2] == REG_CTRL)) ctrl <= ctrl_t'(bus.DAT_I & CTRL_WMASK);
        end
    end

    // anode and cathode registered together so they never disagree
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            O_anode   <= '0;
            O_cathode <= SEG_OFF;
        end else begin
            O_anode   <= lit ? 8'd1 << digit : 8'd0;
            O_cathode <= lit ? seg : SEG_OFF;
        end
    end
endmodule
